// File: rtl/rv_lsu_ctrl.sv
// Byte-addressed load/store sequencer in front of a word memory; sub-word stores are read-modify-write.
// Latency to rsp_valid_o: error 1, load 2, word store 2, sub-word store 3; holds in RESP until rsp_ready_i.
module rv_lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DMEM_DEPTH = 1024,
  parameter int IDX_WIDTH  = $clog2(DMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic                  req_wr_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [IDX_WIDTH-1:0]  dmem_addr_o,
  output logic                  dmem_wr_o,
  output logic [31:0]           dmem_wr_data_o,
  input  logic [31:0]           dmem_data_i
);

  localparam int LA = IDX_WIDTH + 2;

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_t;
  state_t state, state_d;

  logic [LA-1:0]         addr_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic [31:0]           wdata_q;
  logic [31:0]           old_q;
  logic [31:0]           rdata_q;
  logic                  err_q;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  req_err;
  logic                  accept;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_ext;
  logic [31:0]           wr_word;

  assign word_idx = req_addr_i >> 2;
  assign accept   = (state == IDLE) && req_valid_i;

  always_comb begin
    req_err = 1'b0;
    if (req_size_i == 2'd3)                         req_err = 1'b1;
    if (req_size_i == 2'd1 && req_addr_i[0])        req_err = 1'b1;
    if (req_size_i == 2'd2 && |req_addr_i[1:0])     req_err = 1'b1;
    if (word_idx >= ADDR_WIDTH'(DMEM_DEPTH))        req_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err)                  state_d = RESP;
          else if (!req_wr_i)           state_d = LOAD;
          else if (req_size_i == 2'd2)  state_d = WRITE;
          else                          state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = WRITE;
      WRITE:   state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lane select on the live memory read while in LOAD, then extend.
  always_comb begin
    ld_byte = dmem_data_i[{addr_q[1:0], 3'b000} +: 8];
    ld_half = addr_q[1] ? dmem_data_i[31:16] : dmem_data_i[15:0];
    case (size_q)
      2'd0:    ld_ext = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      2'd1:    ld_ext = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_ext = dmem_data_i;
    endcase
  end

  always_comb begin
    wr_word = old_q;
    case (size_q)
      2'd0: wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      2'd1: begin
        if (addr_q[1]) wr_word[31:16] = wdata_q[15:0];
        else           wr_word[15:0]  = wdata_q[15:0];
      end
      default: wr_word = wdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_i[LA-1:0];
        size_q  <= req_size_i;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == LOAD)   rdata_q <= ld_ext;
      if (state == RMW_RD) old_q   <= dmem_data_i;
    end
  end

  assign req_ready_o    = (state == IDLE);
  assign rsp_valid_o    = (state == RESP);
  assign rsp_rdata_o    = rdata_q;
  assign rsp_err_o      = err_q;
  assign dmem_addr_o    = addr_q[LA-1:2];
  // Reset suppresses a strobe already sitting in WRITE so the write never lands.
  assign dmem_wr_o      = (state == WRITE) && !reset;
  assign dmem_wr_data_o = (state == WRITE) ? wr_word : 32'd0;

endmodule

// File: tb/tb_rv_lsu_ctrl.sv
// Bench for rv_lsu_ctrl: word memory model plus a transaction-level reference for loads, stores and errors.
module tb_rv_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        req_wr_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic [9:0]  dmem_addr_o;
  logic        dmem_wr_o;
  logic [31:0] dmem_wr_data_o;
  logic [31:0] dmem_data_i;

  rv_lsu_ctrl #(.ADDR_WIDTH(32), .DMEM_DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_wr_i(req_wr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i), .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wr_o(dmem_wr_o), .dmem_wr_data_o(dmem_wr_data_o), .dmem_data_i(dmem_data_i)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        preload;

  assign dmem_data_i = mem[dmem_addr_o];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++) mem[i] <= ref_mem[i];
    end else if (dmem_wr_o) begin
      mem[dmem_addr_o] <= dmem_wr_data_o;
    end
  end

  int vectors    = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic model_err(input logic [31:0] a, input logic [1:0] size);
    if (size == 2'd3) return 1'b1;
    if (size == 2'd1 && a % 2 != 0) return 1'b1;
    if (size == 2'd2 && a % 4 != 0) return 1'b1;
    return (a / 4) >= 1024;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int sh;
    sh = 8 * (a % 4);
    if (size == 2'd2) return w;
    if (size == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 32'd128) v = v | 32'hFFFFFF00;
    end else begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32'd32768) v = v | 32'hFFFF0000;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [1:0] size);
    logic [31:0] mask;
    int sh;
    if (size == 2'd2) return wd;
    sh   = 8 * (a % 4);
    mask = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((wd << sh) & mask);
  endfunction

  // Drives one request from an IDLE negedge and checks it cycle by cycle against the model.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic er);
    logic        e;
    int          lat, wcyc, c;
    logic [9:0]  idx;
    logic [31:0] exp_rd, exp_w;
    logic        seen;
    e      = model_err(addr, size);
    idx    = addr[11:2];
    lat    = e ? 1 : (!wr ? 2 : (size == 2'd2 ? 2 : 3));
    wcyc   = (!e && wr) ? (size == 2'd2 ? 1 : 2) : 0;
    exp_rd = (e || wr) ? 32'd0 : model_load(ref_mem[idx], addr, size, uns);
    exp_w  = model_store(ref_mem[idx], wdata, addr, size);
    check("req_ready_idle", {31'd0, req_ready_o}, 32'd1);
    req_valid_i = 1'b1; req_wr_i = wr; req_size_i = size;
    req_unsigned_i = uns; req_addr_i = addr; req_wdata_i = wdata;
    seen = 1'b0;
    c = 0;
    while (!seen && c < 20) begin
      @(negedge clk);
      c++;
      if (c == 1) begin
        // A second request while busy must be ignored.
        req_valid_i = 1'($urandom_range(0, 1));
        req_wr_i = 1'($urandom_range(0, 1)); req_size_i = 2'($urandom_range(0, 3));
        req_addr_i = $urandom; req_wdata_i = $urandom;
      end
      check("wr_strobe", {31'd0, dmem_wr_o}, {31'd0, (c == wcyc)});
      if (c == wcyc) begin
        check("wr_data", dmem_wr_data_o, exp_w);
        check("wr_addr", {22'd0, dmem_addr_o}, {22'd0, idx});
      end
      if (rsp_valid_o) seen = 1'b1;
      else check("req_ready_busy", {31'd0, req_ready_o}, 32'd0);
    end
    check("rsp_latency", c, lat);
    for (int h = 0; h <= hold; h++) begin
      check("rsp_valid_held", {31'd0, rsp_valid_o}, 32'd1);
      check("rsp_rdata", rsp_rdata_o, exp_rd);
      check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e});
      check("req_ready_resp", {31'd0, req_ready_o}, 32'd0);
      check("wr_in_resp", {31'd0, dmem_wr_o}, 32'd0);
      if (h < hold) @(negedge clk);
    end
    rd = rsp_rdata_o;
    er = rsp_err_o;
    rsp_ready_i = 1'b1;
    req_valid_i = 1'b0;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check("rsp_valid_after_hs", {31'd0, rsp_valid_o}, 32'd0);
    check("req_ready_after_hs", {31'd0, req_ready_o}, 32'd1);
    if (wcyc != 0) ref_mem[idx] = exp_w;
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
    check({tag, "_rsp_err"}, {31'd0, rsp_err_o}, 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_o, 32'd0);
    check({tag, "_dmem_wr"}, {31'd0, dmem_wr_o}, 32'd0);
    check({tag, "_dmem_wr_data"}, dmem_wr_data_o, 32'd0);
    check({tag, "_dmem_addr"}, {22'd0, dmem_addr_o}, 32'd0);
  endtask

  // Starts a sub-word store and resets after the given number of cycles (1 = RMW_RD, 2 = WRITE).
  task automatic reset_mid_store(input logic [31:0] addr, input int at_cycle);
    logic [9:0] idx;
    idx = addr[11:2];
    req_valid_i = 1'b1; req_wr_i = 1'b1; req_size_i = 2'd0;
    req_unsigned_i = 1'b0; req_addr_i = addr; req_wdata_i = 32'h000000A5;
    for (int i = 0; i < at_cycle; i++) begin
      @(negedge clk);
      req_valid_i = 1'b0;
      if (i < at_cycle - 1) check("rst_pre_wr", {31'd0, dmem_wr_o}, 32'd0);
    end
    reset = 1'b1;
    #1;
    check("rst_wr_suppressed", {31'd0, dmem_wr_o}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("rst_mid");
    check("rst_mid_ready", {31'd0, req_ready_o}, 32'd1);
    @(negedge clk);
    check("rst_mid_ready2", {31'd0, req_ready_o}, 32'd1);
    check("rst_mid_mem", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  logic        er;

  initial begin
    reset = 1'b1; preload = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_wr_i = 1'b0; req_size_i = '0;
    req_unsigned_i = 1'b0; req_wdata_i = '0; rsp_ready_i = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h8899AABB;
    @(negedge clk);
    @(negedge clk);
    preload = 1'b0;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'd0, req_ready_o}, 32'd1);

    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, rd, er);
    check("lit_lb_13", rd, 32'hFFFFFF88);
    check("lit_lb_13_err", {31'd0, er}, 32'd0);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, rd, er);
    check("lit_lbu_13", rd, 32'h00000088);
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000CC, 0, rd, er);
    check("lit_sb_11_mem", mem[4], 32'h8899CCBB);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, 0, rd, er);
    check("lit_lw_10", rd, 32'h8899CCBB);
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 0, rd, er);
    check("lit_sw_20_mem", mem[8], 32'hDEADBEEF);
    do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234, 0, rd, er);
    check("lit_sh_22_mem", mem[8], 32'h1234BEEF);
    do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'd0, 0, rd, er);
    check("lit_lh_22", rd, 32'h00001234);
    do_req(1'b0, 2'd1, 1'b0, 32'h20, 32'd0, 0, rd, er);
    check("lit_lh_20_sext", rd, 32'hFFFFBEEF);

    do_req(1'b0, 2'd2, 1'b0, 32'h6, 32'd0, 0, rd, er);
    check("lit_err_lw_6", {31'd0, er}, 32'd1);
    do_req(1'b1, 2'd1, 1'b0, 32'h3, 32'hFFFF, 0, rd, er);
    check("lit_err_sh_3", {31'd0, er}, 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h1000, 32'h55555555, 0, rd, er);
    check("lit_err_sw_1000", {31'd0, er}, 32'd1);
    check("lit_err_sw_1000_mem0", mem[0], ref_mem[0]);
    do_req(1'b0, 2'd3, 1'b0, 32'h0, 32'd0, 0, rd, er);
    check("lit_err_size3", {31'd0, er}, 32'd1);
    check("lit_err_size3_rdata", rd, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'hFFC, 32'd0, 0, rd, er);
    check("lit_top_word_ok", {31'd0, er}, 32'd0);

    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'd0, 5, rd, er);
    check("lit_stall_lb_12", rd, 32'hFFFFFF99);

    reset_mid_store(32'h11, 1);
    reset_mid_store(32'h21, 2);
    check("lit_rst_mem4", mem[4], 32'h8899CCBB);

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 11))
        0: a = 32'h1000 + 32'($urandom_range(0, 255));
        1: a = 32'hFFC + 32'($urandom_range(0, 3));
        2: a = $urandom;
        default: ;
      endcase
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom,
             $urandom_range(0, 3), rd, er);
    end

    for (int i = 0; i < 1024; i++) begin
      if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
    end
    check("final_mem4", mem[4], ref_mem[4]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_lsu_ctrl.md
Name: rv_lsu_ctrl

Overview:
Load/store sequencer between the RV32I core's memory stage and the word-addressed data memory. The memory has a combinational read, a synchronous write and 32-bit words only.
- Accepts byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW requests over a valid/ready handshake.
- Sub-word stores are done as read-modify-write.
- Load data is extracted and sign- or zero-extended.
- Misaligned and out-of-range accesses are flagged as errors.

Parameters:
ADDR_WIDTH, 32, width of the core's byte address.
DMEM_DEPTH, 1024, number of 32-bit words in the data memory.
IDX_WIDTH, $clog2(DMEM_DEPTH) = 10, width of the word index driven to the memory.

Ports:
clk  in  1  clock; all state changes on its rising edge.
reset  in  1  synchronous, active-high reset.
req_valid_i  in  1  core request valid.
req_ready_o  out  1  controller can accept a request; high only in IDLE.
req_addr_i  in  ADDR_WIDTH  byte address.
req_wr_i  in  1  1 = store, 0 = load.
req_size_i  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
req_unsigned_i  in  1  loads only: zero-extend when 1, sign-extend when 0.
req_wdata_i  in  32  store data, right-aligned (bits [7:0] for a byte store).
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  core accepts the response.
rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
rsp_err_o  out  1  misaligned, out-of-range or illegal-size request.
dmem_addr_o  out  IDX_WIDTH  word index, equal to latched byte address [IDX_WIDTH+1:2].
dmem_wr_o  out  1  memory write strobe.
dmem_wr_data_o  out  32  full merged word to write.
dmem_data_i  in  32  combinational memory read of dmem_addr_o.

Behaviour:
- FSM states: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset (synchronous, active-high, dominant in any state including mid-RMW):
  - state returns to IDLE;
  - rsp_valid_o, rsp_err_o, rsp_rdata_o, dmem_wr_o, dmem_wr_data_o and dmem_addr_o are all 0;
  - req_ready_o is 1 from the first cycle after reset deasserts;
  - a write pending in WRITE is not issued.
- Accept: in IDLE with req_valid_i high, latch addr, wr, size, unsigned and wdata. Error check on accept:
  - misaligned when half and addr[0]!=0, or word and addr[1:0]!=0;
  - out of range when addr>>2 >= DMEM_DEPTH;
  - illegal when size=3;
  - on error, go to RESP with rsp_err_o=1 and perform no memory access.
- Transitions for a legal request:
  - load: IDLE -> LOAD;
  - word store: IDLE -> WRITE;
  - byte or half store: IDLE -> RMW_RD.
- LOAD: select lane by addr[1:0], then extend. Byte lanes: [7:0], [15:8], [23:16], [31:24]. Half lanes: [15:0] for addr[1]=0, [31:16] for addr[1]=1. Register the result into rsp_rdata_o, then go to RESP.
- RMW_RD: capture dmem_data_i into an internal old-word register, then go to WRITE.
- WRITE: dmem_wr_o=1 for exactly one cycle. dmem_wr_data_o is either the latched wdata (word store) or the old word with only the addressed byte/half lane replaced. Then go to RESP. Bytes outside the lane are never altered.
- RESP: rsp_valid_o held high with stable rsp_rdata_o/rsp_err_o until rsp_ready_i=1, then IDLE. No back-to-back acceptance: req_ready_o is low in RESP.
- dmem_wr_o is 0 in every state except WRITE. dmem_addr_o holds the latched index outside IDLE.
- Latency, with accept in cycle 0:
  - error: rsp_valid_o in cycle 1;
  - load: cycle 2;
  - word store: write at end of cycle 1, rsp_valid_o in cycle 2;
  - sub-word store: read in cycle 1, write at end of cycle 2, rsp_valid_o in cycle 3.
- rsp_ready_i held low stalls indefinitely in RESP. New req_valid_i is ignored while not IDLE.

Test Plan:
- mem[4]=0x8899AABB; LB addr 0x13 -> rsp_rdata 0xFFFFFF88, err 0, rsp_valid at cycle 2; LBU addr 0x13 -> 0x00000088.
- mem[4]=0x8899AABB; SB addr 0x11, wdata 0x000000CC -> dmem_wr_o exactly one pulse in cycle 2 with data 0x8899CCBB; subsequent LW 0x10 -> 0x8899CCBB.
- SW addr 0x20, wdata 0xDEADBEEF -> one write pulse in cycle 1, mem[8]=0xDEADBEEF; SH addr 0x22, wdata 0x1234 -> mem[8]=0x1234BEEF; LH 0x22 -> 0x00001234.
- LW addr 0x6, SH addr 0x3, any access at addr 0x1000 (index 1024), size=3 -> rsp_err=1 at cycle 1, dmem_wr_o never asserted, memory unchanged.
- Hold rsp_ready_i=0 for 5 cycles after a load -> rsp_valid/rdata stable, req_ready_o=0 throughout, second req_valid_i ignored until handshake completes.
- Assert reset in RMW_RD of an SB -> no write pulse, memory unchanged, next cycle after deassert req_ready_o=1, all outputs 0.
